// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 responder: command classes, FSM states, RAM geometry.
package tm1638_pkg;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);

    // Command class, taken from bits [7:6] of the first byte of a frame
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StRead,
        StIgnore
    } state_e;

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized level.
// Reset flushes the chain high (the idle level of STB, CLK and DIO) so no edge is reported.
module tm1638_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638-compatible serial target: decodes data/display/address commands into a 16-byte
// display RAM. Optional key-scan readback is enabled with the TM1638_KEYSCAN_EN macro.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic              TM1638_STB,
    input  logic              TM1638_CLK,
    input  logic              TM1638_DIO_IN,
`ifdef TM1638_KEYSCAN_EN
    input  logic [31:0]       KEY_IN,
`endif
    output logic              TM1638_DIO_OE,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [7:0]        RD_DATA,
    output logic              DISP_ON,
    output logic [2:0]        BRIGHTNESS,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic              FRAME_ERR
);

    logic stb_lvl, stb_rise, stb_fall;
    logic clk_lvl, clk_rise, clk_fall;
    logic dio_lvl, dio_rise, dio_fall;

    tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk(CLK_IN), .rst(RST_IN), .din(TM1638_STB),
        .level(stb_lvl), .rise(stb_rise), .fall(stb_fall)
    );
    tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(CLK_IN), .rst(RST_IN), .din(TM1638_CLK),
        .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
    );
    tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dio (
        .clk(CLK_IN), .rst(RST_IN), .din(TM1638_DIO_IN),
        .level(dio_lvl), .rise(dio_rise), .fall(dio_fall)
    );

    // Only levels/edges actually needed are consumed; the rest are collected here
    logic unused_sync;
    assign unused_sync = ^{stb_lvl, clk_lvl, dio_rise, dio_fall, clk_fall};

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              fixed_q, fixed_d;
    logic              disp_on_q, disp_on_d;
    logic [2:0]        bright_q, bright_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        rd_data_q;
    logic [7:0]        ram_q [RAM_DEPTH];
    logic              wr_en;
    logic [7:0]        new_byte;
    logic              byte_done;
`ifdef TM1638_KEYSCAN_EN
    logic              read_mode_q, read_mode_d;
    logic [5:0]        key_cnt_q, key_cnt_d;
    logic              dio_oe_q, dio_oe_d;
`endif

    // Byte as it will look once the current DIO bit is shifted in (LSB first)
    assign new_byte  = {dio_lvl, shift_q[7:1]};
    assign byte_done = (state_q != StIdle) && clk_rise && (bit_cnt_q == 3'd7);

    // Next-state: bit shifting, command decode, RAM writes, frame boundaries
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        fixed_d     = fixed_q;
        disp_on_d   = disp_on_q;
        bright_d    = bright_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
`ifdef TM1638_KEYSCAN_EN
        read_mode_d = read_mode_q;
        key_cnt_d   = key_cnt_q;
        dio_oe_d    = dio_oe_q;
`endif

        if (state_q != StIdle && clk_rise) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
            case (state_q)
                StCmd: begin
                    case (new_byte[7:6])
                        CMD_DATA: begin
                            fixed_d = new_byte[2];
                            state_d = new_byte[1] ? StRead : StIgnore;
`ifdef TM1638_KEYSCAN_EN
                            read_mode_d = new_byte[1];
                            key_cnt_d   = '0;
`endif
                        end
                        CMD_DISP: begin
                            disp_on_d = new_byte[3];
                            bright_d  = new_byte[2:0];
                            state_d   = StIgnore;
                        end
                        CMD_ADDR: begin
                            ptr_d   = new_byte[ADDR_W-1:0];
                            state_d = StData;
                        end
                        default: state_d = StIgnore;
                    endcase
                end
                StData: begin
                    wr_en     = 1'b1;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    if (!fixed_q) ptr_d = ptr_q + 1'b1;
                end
                default: ;
            endcase
        end

`ifdef TM1638_KEYSCAN_EN
        // Drive the next key bit after each falling CLK; release after the 32nd rising CLK
        if (state_q == StRead && read_mode_q) begin
            if (clk_fall && key_cnt_q != 6'd32) begin
                dio_oe_d  = ~KEY_IN[key_cnt_q[4:0]];
                key_cnt_d = key_cnt_q + 6'd1;
            end
            if (clk_rise && key_cnt_q == 6'd32) begin
                dio_oe_d = 1'b0;
                state_d  = StIgnore;
            end
        end
`endif

        // Frame boundaries override everything; a byte completing with STB rise still commits
        if (stb_rise) begin
            frame_err_d = (state_q != StIdle) && (bit_cnt_d != 3'd0);
            state_d     = StIdle;
            bit_cnt_d   = 3'd0;
        end else if (stb_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
        end

`ifdef TM1638_KEYSCAN_EN
        if (state_d != StRead) dio_oe_d = 1'b0;
`endif
    end

    // State, configuration and display RAM registers
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            fixed_q     <= 1'b0;
            disp_on_q   <= 1'b0;
            bright_q    <= 3'd0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            rd_data_q   <= 8'h00;
            for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
`ifdef TM1638_KEYSCAN_EN
            read_mode_q <= 1'b0;
            key_cnt_q   <= 6'd0;
            dio_oe_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            fixed_q     <= fixed_d;
            disp_on_q   <= disp_on_d;
            bright_q    <= bright_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= ram_q[RD_ADDR];
            if (wr_en) ram_q[ptr_q] <= new_byte;
`ifdef TM1638_KEYSCAN_EN
            read_mode_q <= read_mode_d;
            key_cnt_q   <= key_cnt_d;
            dio_oe_q    <= dio_oe_d;
`endif
        end
    end

`ifdef TM1638_KEYSCAN_EN
    assign TM1638_DIO_OE = dio_oe_q;
`else
    assign TM1638_DIO_OE = 1'b0;
`endif
    assign RD_DATA    = rd_data_q;
    assign DISP_ON    = disp_on_q;
    assign BRIGHTNESS = bright_q;
    assign WR_STB     = wr_stb_q;
    assign WR_ADDR    = wr_addr_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder; key-scan test runs when TM1638_KEYSCAN_EN is defined.
module tb_tm1638_responder;

    localparam int HALF = 6;  // system cycles per TM1638 half period

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stb, tmclk, dio_tb;
    logic [3:0]  rd_addr;
    logic        dio_oe, disp_on, wr_stb, frame_err;
    logic [7:0]  rd_data;
    logic [2:0]  brightness;
    logic [3:0]  wr_addr;
    logic        dio_line;
`ifdef TM1638_KEYSCAN_EN
    logic [31:0] key_in;
`endif

    int passes = 0;
    int checks = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    logic [3:0] wr_log [64];

    // Open-drain line: initiator releases (1) or pulls low, target pulls low via OE
    assign dio_line = dio_tb & ~dio_oe;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .CLK_IN(clk_in),
        .RST_IN(rst_in),
        .TM1638_STB(stb),
        .TM1638_CLK(tmclk),
        .TM1638_DIO_IN(dio_line),
`ifdef TM1638_KEYSCAN_EN
        .KEY_IN(key_in),
`endif
        .TM1638_DIO_OE(dio_oe),
        .RD_ADDR(rd_addr),
        .RD_DATA(rd_data),
        .DISP_ON(disp_on),
        .BRIGHTNESS(brightness),
        .WR_STB(wr_stb),
        .WR_ADDR(wr_addr),
        .FRAME_ERR(frame_err)
    );

    always #5 clk_in = ~clk_in;

    // Count write and frame-error pulses (one count per cycle high)
    always @(negedge clk_in) begin
        if (wr_stb) begin
            wr_log[wr_cnt[5:0]] <= wr_addr;
            wr_cnt <= wr_cnt + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic half_wait();
        repeat (HALF) @(negedge clk_in);
    endtask

    task automatic frame_start();
        stb = 1'b0;
        half_wait();
    endtask

    task automatic frame_end();
        stb = 1'b1;
        dio_tb = 1'b1;
        half_wait();
        half_wait();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            dio_tb = b[i];
            tmclk  = 1'b0;
            half_wait();
            tmclk  = 1'b1;
            half_wait();
        end
    endtask

    task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk_in);
        rd_addr = a;
        @(negedge clk_in);
        @(negedge clk_in);
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        checks++; if ({disp_on, brightness, wr_stb, wr_addr, frame_err, dio_oe, rd_data} !== 19'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {disp_on, brightness, wr_stb, wr_addr, frame_err, dio_oe, rd_data});
        else passes++;
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        read_ram(4'd7, d);
        checks++; if (d !== 8'h00) $display("FAIL reset_ram7: got %h want 00", d); else passes++;
    endtask

    task automatic test_disp_ctrl();
        int w0 = wr_cnt;
        frame_start(); send_bits(8'h8F, 8); frame_end();
        checks++; if (disp_on !== 1'b1) $display("FAIL disp_on_8f: got %b want 1", disp_on);
        else passes++;
        checks++; if (brightness !== 3'd7) $display("FAIL bright_8f: got %0d want 7", brightness);
        else passes++;
        checks++; if (wr_cnt != w0) $display("FAIL disp_no_write: got %0d want 0", wr_cnt - w0);
        else passes++;
        frame_start(); send_bits(8'h83, 8); frame_end();
        checks++; if ({disp_on, brightness} !== 4'b0011)
            $display("FAIL disp_83: got %b want 0011", {disp_on, brightness});
        else passes++;
    endtask

    task automatic test_write_fixed();
        logic [7:0] d;
        int w0 = wr_cnt;
        frame_start(); send_bits(8'h44, 8); frame_end();
        frame_start(); send_bits(8'hC0, 8); send_bits(8'h3F, 8); frame_end();
        frame_start(); send_bits(8'hC2, 8); send_bits(8'h06, 8); frame_end();
        checks++; if (wr_cnt - w0 != 2) $display("FAIL fixed_wr_cnt: got %0d want 2", wr_cnt - w0);
        else passes++;
        checks++; if (wr_log[w0[5:0]] !== 4'd0)
            $display("FAIL fixed_wr_addr0: got %0d want 0", wr_log[w0[5:0]]);
        else passes++;
        checks++; if (wr_log[6'(w0 + 1)] !== 4'd2)
            $display("FAIL fixed_wr_addr1: got %0d want 2", wr_log[6'(w0 + 1)]);
        else passes++;
        read_ram(4'd0, d);
        checks++; if (d !== 8'h3F) $display("FAIL fixed_ram0: got %h want 3f", d); else passes++;
        read_ram(4'd2, d);
        checks++; if (d !== 8'h06) $display("FAIL fixed_ram2: got %h want 06", d); else passes++;
        read_ram(4'd1, d);
        checks++; if (d !== 8'h00) $display("FAIL fixed_ram1: got %h want 00", d); else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        int w0 = wr_cnt;
        frame_start(); send_bits(8'h40, 8); frame_end();
        frame_start(); send_bits(8'hCF, 8); send_bits(8'hAA, 8); send_bits(8'h55, 8); frame_end();
        checks++; if (wr_cnt - w0 != 2) $display("FAIL wrap_wr_cnt: got %0d want 2", wr_cnt - w0);
        else passes++;
        checks++; if (wr_log[6'(w0 + 1)] !== 4'd0)
            $display("FAIL wrap_wr_addr: got %0d want 0", wr_log[6'(w0 + 1)]);
        else passes++;
        read_ram(4'd15, d);
        checks++; if (d !== 8'hAA) $display("FAIL wrap_ram15: got %h want aa", d); else passes++;
        read_ram(4'd0, d);
        checks++; if (d !== 8'h55) $display("FAIL wrap_ram0: got %h want 55", d); else passes++;
    endtask

    task automatic test_ignore();
        int w0 = wr_cnt;
        frame_start(); send_bits(8'h00, 8); send_bits(8'h12, 8); frame_end();
        frame_start(); send_bits(8'h8A, 8); send_bits(8'hC5, 8); frame_end();
        checks++; if (wr_cnt != w0) $display("FAIL ignore_no_write: got %0d want 0", wr_cnt - w0);
        else passes++;
        checks++; if ({disp_on, brightness} !== 4'b1010)
            $display("FAIL ignore_disp: got %b want 1010", {disp_on, brightness});
        else passes++;
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        int w0 = wr_cnt;
        int f0 = fe_cnt;
        frame_start(); send_bits(8'hC3, 8); send_bits(8'hFF, 5); frame_end();
        checks++; if (fe_cnt - f0 != 1) $display("FAIL frame_err_cnt: got %0d want 1", fe_cnt - f0);
        else passes++;
        checks++; if (wr_cnt != w0) $display("FAIL frame_err_write: got %0d want 0", wr_cnt - w0);
        else passes++;
        read_ram(4'd3, d);
        checks++; if (d !== 8'h00) $display("FAIL frame_err_ram3: got %h want 00", d); else passes++;
    endtask

    // 8th CLK rise and STB rise land in the same cycle: byte commits, no error
    task automatic test_stb_commit();
        logic [7:0] d;
        int w0 = wr_cnt;
        int f0 = fe_cnt;
        frame_start(); send_bits(8'hC4, 8); send_bits(8'h5A, 7);
        dio_tb = 1'b0;
        tmclk  = 1'b0;
        half_wait();
        tmclk  = 1'b1;
        stb    = 1'b1;
        half_wait();
        frame_end();
        checks++; if (wr_cnt - w0 != 1) $display("FAIL commit_wr_cnt: got %0d want 1", wr_cnt - w0);
        else passes++;
        checks++; if (fe_cnt != f0) $display("FAIL commit_no_err: got %0d want 0", fe_cnt - f0);
        else passes++;
        read_ram(4'd4, d);
        checks++; if (d !== 8'h5A) $display("FAIL commit_ram4: got %h want 5a", d); else passes++;
    endtask

`ifdef TM1638_KEYSCAN_EN
    task automatic test_keyscan();
        logic [31:0] got;
        key_in = 32'h04030201;
        got = '0;
        frame_start(); send_bits(8'h42, 8);
        dio_tb = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tmclk = 1'b0;
            half_wait();
            tmclk = 1'b1;
            got[i] = dio_line;
            half_wait();
        end
        frame_end();
        for (int b = 0; b < 4; b++) begin
            checks++; if (got[b*8 +: 8] !== 8'(b + 1))
                $display("FAIL key_byte%0d: got %h want %h", b, got[b*8 +: 8], 8'(b + 1));
            else passes++;
        end
        checks++; if (dio_oe !== 1'b0) $display("FAIL key_release: got %b want 0", dio_oe);
        else passes++;
    endtask
`else
    task automatic test_keyscan();
        int w0 = wr_cnt;
        int oe_seen = 0;
        frame_start(); send_bits(8'h42, 8);
        for (int i = 0; i < 8; i++) begin
            tmclk = 1'b0;
            half_wait();
            tmclk = 1'b1;
            if (dio_oe) oe_seen++;
            half_wait();
        end
        frame_end();
        checks++; if (oe_seen != 0) $display("FAIL read_oe_tied: got %0d want 0", oe_seen);
        else passes++;
        checks++; if (wr_cnt != w0) $display("FAIL read_no_write: got %0d want 0", wr_cnt - w0);
        else passes++;
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] d;
        int w0, f0;
        frame_start(); send_bits(8'h8F, 8); frame_end();
        w0 = wr_cnt;
        f0 = fe_cnt;
        frame_start(); send_bits(8'hC6, 8); send_bits(8'hFF, 3);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        stb   = 1'b1;
        tmclk = 1'b1;
        dio_tb = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if ({disp_on, brightness, wr_stb, wr_addr, frame_err, dio_oe, rd_data} !== 19'd0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {disp_on, brightness, wr_stb, wr_addr, frame_err, dio_oe, rd_data});
        else passes++;
        rst_in = 1'b0;
        half_wait();
        checks++; if (wr_cnt != w0 || fe_cnt != f0)
            $display("FAIL midreset_no_pulse: got wr %0d err %0d want 0 0", wr_cnt - w0, fe_cnt - f0);
        else passes++;
        read_ram(4'd0, d);
        checks++; if (d !== 8'h00) $display("FAIL midreset_ram0: got %h want 00", d); else passes++;
        frame_start(); send_bits(8'h8F, 8); frame_end();
        checks++; if ({disp_on, brightness} !== 4'b1111)
            $display("FAIL midreset_8f: got %b want 1111", {disp_on, brightness});
        else passes++;
    endtask

    initial begin
        rst_in  = 1'b1;
        stb     = 1'b1;
        tmclk   = 1'b1;
        dio_tb  = 1'b1;
        rd_addr = 4'd0;
`ifdef TM1638_KEYSCAN_EN
        key_in  = '0;
`endif
        test_reset();
        test_disp_ctrl();
        test_write_fixed();
        test_wrap();
        test_ignore();
        test_frame_err();
        test_stb_commit();
        test_keyscan();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on TM1638_STB, TM1638_CLK and TM1638_DIO_IN (minimum 2).
REQ-002 SHALL have port CLK_IN, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST_IN, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port TM1638_STB, input, 1 bit: strobe from the initiator; low means frame active.
REQ-005 SHALL have port TM1638_CLK, input, 1 bit: serial clock from the initiator; data is sampled on its rising edge.
REQ-006 SHALL have port TM1638_DIO_IN, input, 1 bit: line level of the open-drain DIO.
REQ-007 SHALL have port TM1638_DIO_OE, output, 1 bit: pulls DIO low when 1 and releases it when 0.
REQ-008 SHALL have port RD_ADDR, input, 4 bits: display RAM read address.
REQ-009 SHALL have port RD_DATA, output, 8 bits: RAM[RD_ADDR], registered with 1-cycle latency.
REQ-010 SHALL have port DISP_ON, output, 1 bit: display-enable bit from the last display-control command.
REQ-011 SHALL have port BRIGHTNESS, output, 3 bits: brightness from the last display-control command.
REQ-012 SHALL have port WR_STB, output, 1 bit: one-cycle pulse on each RAM write.
REQ-013 SHALL have port WR_ADDR, output, 4 bits: address of the RAM write, valid with WR_STB.
REQ-014 SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse when a frame ends with a partial byte.

Function
REQ-015 SHALL detect edges on the synchronized signals only; raw pins SHALL NOT feed logic.
REQ-016 SHALL shift bits in LSB first, one bit per synchronized TM1638_CLK rising edge while STB is low; the 8th bit completes a byte.
REQ-017 SHALL use FSM states IDLE, CMD, DATA, READ and IGNORE; a falling STB edge goes to CMD with the bit counter at 0; a rising STB edge returns to IDLE from any state.
REQ-018 SHALL decode the first byte in CMD by bits[7:6]: 01 = data command, 10 = display control, 11 = address set, 00 = ignored (goes to IGNORE).
REQ-019 SHALL, on a data command, store bit2 (1 = fixed address, 0 = auto-increment) and bit1 (1 = key read), then enter READ if bit1=1, else IGNORE.
REQ-020 SHALL, on display control, load DISP_ON=bit3 and BRIGHTNESS=bits[2:0], then go to IGNORE.
REQ-021 SHALL, on address set, load the address pointer with bits[3:0] and go to DATA.
REQ-022 SHALL, in DATA, write each completed byte to RAM[pointer], pulse WR_STB with WR_ADDR=pointer one CLK_IN cycle after the completing edge is detected, and increment the pointer modulo 16 when in auto mode (15 wraps to 0).
REQ-023 SHALL keep the address pointer and mode across frames.
REQ-024 SHALL commit the byte when the 8th rising edge and the rising STB edge are detected in the same cycle; otherwise a rising STB with a nonzero bit count SHALL pulse FRAME_ERR and discard the partial byte.
REQ-025 SHALL ignore all bytes received in IGNORE.
REQ-026 SHALL keep TM1638_DIO_OE at 0 in every state except READ.

Reset
REQ-027 SHALL, while RST_IN=1 at a clock edge, clear all RAM entries to 0x00, clear DISP_ON, BRIGHTNESS, TM1638_DIO_OE, WR_STB, WR_ADDR, FRAME_ERR and RD_DATA to 0, set the pointer to 0, set the mode to write/auto-increment, set the FSM to IDLE and flush the synchronizers to STB=1, CLK=1, DIO=1.
REQ-028 SHALL abandon any frame in progress on reset, with no RAM write and no FRAME_ERR, and SHALL wait for the next falling STB edge.

Configuration
REQ-029 SHALL, with TM1638_KEYSCAN_EN defined, add input port KEY_IN, 32 bits, and in READ drive KEY_IN LSB first, bytes 0 to 3, updating TM1638_DIO_OE = ~bit on each synchronized falling CLK edge, releasing the line after bit 31, then entering IGNORE.
REQ-030 SHALL, without TM1638_KEYSCAN_EN, have no KEY_IN port, treat READ like IGNORE, and tie TM1638_DIO_OE to 0.

Structure
REQ-031 SHALL place the command-class codes (2'b01, 2'b10, 2'b11), the FSM state encoding and the RAM depth of 16 in shared package tm1638_pkg.
REQ-032 SHALL implement synchronization and edge detection in sub-module tm1638_sync_edge, instanced for STB, CLK and DIO.

Verification
REQ-033 SHALL check: frame 0x8F -> DISP_ON=1, BRIGHTNESS=7, no WR_STB.
REQ-034 SHALL check: frames 0x44, then 0xC0+0x3F, then 0xC2+0x06 -> RAM[0]=0x3F, RAM[2]=0x06, exactly two WR_STB pulses, with WR_ADDR 0 then 2.
REQ-035 SHALL check: frames 0x40, then 0xCF+0xAA+0x55 -> RAM[15]=0xAA, RAM[0]=0x55 (wrap-around).
REQ-036 SHALL check: STB rises after 5 bits of an address-set data byte -> one FRAME_ERR pulse, RAM unchanged.
REQ-037 SHALL check: RST_IN=1 mid-byte in DATA -> all outputs 0, no write; next frame 0x8F still decoded correctly.
REQ-038 SHALL check, with TM1638_KEYSCAN_EN: KEY_IN=0x04030201, frame 0x42 plus 32 clocks -> the initiator samples bytes 0x01, 0x02, 0x03, 0x04 on rising CLK, and TM1638_DIO_OE=0 after STB rises.
